// File: rtl/czonotope_mem_pkg.sv
// rtl/czonotope_mem_pkg.sv - shared defaults, width helpers and dimension record for czonotope_mem
package czonotope_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NMAX       = 10;
  localparam int DEF_NGMAX      = 5;
  localparam int DEF_NCMAX      = 3;

  // Address width for a RAM holding max_val entries; never below one bit.
  function automatic int addr_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  // A dimension register must be able to hold the maximum itself.
  function automatic int dim_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DIM_N_W  = dim_w(DEF_NMAX);
  localparam int DIM_NG_W = dim_w(DEF_NGMAX);
  localparam int DIM_NC_W = dim_w(DEF_NCMAX);

  typedef struct packed {
    logic [DIM_N_W-1:0]  n;
    logic [DIM_NG_W-1:0] ng;
    logic [DIM_NC_W-1:0] nc;
  } dims_t;

endpackage

// File: rtl/czonotope_mem_if.sv
// rtl/czonotope_mem_if.sv - dimension and RAM access bus for czonotope_mem
interface czonotope_mem_if
  import czonotope_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NMAX       = DEF_NMAX,
  parameter int NGMAX      = DEF_NGMAX,
  parameter int NCMAX      = DEF_NCMAX
);
  localparam int AN  = addr_w(NMAX);
  localparam int AG  = addr_w(NGMAX);
  localparam int AC  = addr_w(NCMAX);
  localparam int NW  = dim_w(NMAX);
  localparam int NGW = dim_w(NGMAX);
  localparam int NCW = dim_w(NCMAX);

  logic                  dim_we;
  logic [NW-1:0]         n_wdata;
  logic [NGW-1:0]        ng_wdata;
  logic [NCW-1:0]        nc_wdata;
  logic [NW-1:0]         n;
  logic [NGW-1:0]        ng;
  logic [NCW-1:0]        nc;

  logic                  c_we;
  logic [AN-1:0]         c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  G_we;
  logic [AN-1:0]         G_raddr;
  logic [AG-1:0]         G_caddr;
  logic [DATA_WIDTH-1:0] G_wdata;
  logic [DATA_WIDTH-1:0] G_rdata;

  logic                  A_we;
  logic [AC-1:0]         A_raddr;
  logic [AG-1:0]         A_caddr;
  logic [DATA_WIDTH-1:0] A_wdata;
  logic [DATA_WIDTH-1:0] A_rdata;

  logic                  b_we;
  logic [AC-1:0]         b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output dim_we, n_wdata, ng_wdata, nc_wdata,
    output c_we, c_addr, c_wdata,
    output G_we, G_raddr, G_caddr, G_wdata,
    output A_we, A_raddr, A_caddr, A_wdata,
    output b_we, b_addr, b_wdata,
    input  n, ng, nc, c_rdata, G_rdata, A_rdata, b_rdata
  );

  modport slave (
    input  dim_we, n_wdata, ng_wdata, nc_wdata,
    input  c_we, c_addr, c_wdata,
    input  G_we, G_raddr, G_caddr, G_wdata,
    input  A_we, A_raddr, A_caddr, A_wdata,
    input  b_we, b_addr, b_wdata,
    output n, ng, nc, c_rdata, G_rdata, A_rdata, b_rdata
  );

endinterface

// File: rtl/czonotope_mem_ram.sv
// rtl/czonotope_mem_ram.sv - single-port synchronous RAMs (1-D vector and row-major 2-D matrix)
module block_ram_1d #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read and write share the edge, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

module block_ram_2d #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int COL_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ROW_ADDR_WIDTH-1:0] raddr,
  input  logic [COL_ADDR_WIDTH-1:0] caddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ROW_ADDR_WIDTH][2**COL_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[raddr][caddr] <= wdata;
    end
    rdata <= mem[raddr][caddr];
  end

endmodule

// File: rtl/czonotope_mem.sv
// rtl/czonotope_mem.sv - constrained-zonotope storage: c, G, A, b RAMs plus dimension registers
module czonotope_mem
  import czonotope_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NMAX       = DEF_NMAX,
  parameter int NGMAX      = DEF_NGMAX,
  parameter int NCMAX      = DEF_NCMAX
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  czonotope_mem_if.slave   bus
);

  localparam int AN  = addr_w(NMAX);
  localparam int AG  = addr_w(NGMAX);
  localparam int AC  = addr_w(NCMAX);
  localparam int NW  = dim_w(NMAX);
  localparam int NGW = dim_w(NGMAX);
  localparam int NCW = dim_w(NCMAX);

  localparam logic [NW-1:0]  N_LIM  = NW'(NMAX);
  localparam logic [NGW-1:0] NG_LIM = NGW'(NGMAX);
  localparam logic [NCW-1:0] NC_LIM = NCW'(NCMAX);

  dims_t                 dims;
  dims_t                 dims_next;
  logic                  dims_legal;
  logic                  rd_ok;
  logic                  run;
  logic [DATA_WIDTH-1:0] c_q;
  logic [DATA_WIDTH-1:0] g_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  assign run = rstn_i;

  always_comb begin
    dims_next    = dims;
    dims_next.n  = DIM_N_W'(bus.n_wdata);
    dims_next.ng = DIM_NG_W'(bus.ng_wdata);
    dims_next.nc = DIM_NC_W'(bus.nc_wdata);
    dims_legal   = (bus.n_wdata <= N_LIM) && (bus.ng_wdata <= NG_LIM) &&
                   (bus.nc_wdata <= NC_LIM);
  end

  // rd_ok masks the un-reset RAM output registers until the first edge after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dims  <= '0;
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= 1'b1;
      if (bus.dim_we && dims_legal) begin
        dims <= dims_next;
      end
    end
  end

  assign bus.n  = NW'(dims.n);
  assign bus.ng = NGW'(dims.ng);
  assign bus.nc = NCW'(dims.nc);

  block_ram_1d #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AN)
  ) i_c (
    .clk   (clk_i),
    .we    (bus.c_we & run),
    .addr  (bus.c_addr),
    .wdata (bus.c_wdata),
    .rdata (c_q)
  );

  block_ram_2d #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ROW_ADDR_WIDTH (AN),
    .COL_ADDR_WIDTH (AG)
  ) i_G (
    .clk   (clk_i),
    .we    (bus.G_we & run),
    .raddr (bus.G_raddr),
    .caddr (bus.G_caddr),
    .wdata (bus.G_wdata),
    .rdata (g_q)
  );

  block_ram_2d #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ROW_ADDR_WIDTH (AC),
    .COL_ADDR_WIDTH (AG)
  ) i_A (
    .clk   (clk_i),
    .we    (bus.A_we & run),
    .raddr (bus.A_raddr),
    .caddr (bus.A_caddr),
    .wdata (bus.A_wdata),
    .rdata (a_q)
  );

  block_ram_1d #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AC)
  ) i_b (
    .clk   (clk_i),
    .we    (bus.b_we & run),
    .addr  (bus.b_addr),
    .wdata (bus.b_wdata),
    .rdata (b_q)
  );

  assign bus.c_rdata = rd_ok ? c_q : '0;
  assign bus.G_rdata = rd_ok ? g_q : '0;
  assign bus.A_rdata = rd_ok ? a_q : '0;
  assign bus.b_rdata = rd_ok ? b_q : '0;

endmodule

// File: tb/tb_czonotope_mem.sv
// tb/tb_czonotope_mem.sv - directed scoreboard bench for czonotope_mem
module tb_czonotope_mem;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  czonotope_mem_if bus ();

  czonotope_mem dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  typedef struct {
    int          ch;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [31:0] rd(input int ch);
    case (ch)
      0:       return bus.c_rdata;
      1:       return bus.G_rdata;
      2:       return bus.A_rdata;
      default: return bus.b_rdata;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic expect_rd(input int ch, input logic [31:0] e, input string tag);
    exp_t x;
    x.ch  = ch;
    x.exp = e;
    x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      check(x.tag, rd(x.ch), x.exp);
    end
  endtask

  task automatic set_dims(input int a, input int g, input int c);
    bus.dim_we   = 1'b1;
    bus.n_wdata  = 4'(a);
    bus.ng_wdata = 3'(g);
    bus.nc_wdata = 2'(c);
    tick();
    bus.dim_we = 1'b0;
  endtask

  task automatic check_dims(input string tag, input int a, input int g, input int c);
    check({tag, "_n"},  32'(bus.n),  32'(a));
    check({tag, "_ng"}, 32'(bus.ng), 32'(g));
    check({tag, "_nc"}, 32'(bus.nc), 32'(c));
  endtask

  initial begin
    bus.dim_we = 1'b0; bus.n_wdata = '0; bus.ng_wdata = '0; bus.nc_wdata = '0;
    bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.G_we = 1'b0; bus.G_raddr = '0; bus.G_caddr = '0; bus.G_wdata = '0;
    bus.A_we = 1'b0; bus.A_raddr = '0; bus.A_caddr = '0; bus.A_wdata = '0;
    bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    dut.i_c.mem[5]    = 32'hDEADBEEF;
    dut.i_G.mem[0][0] = 32'h3F000000;
    dut.i_G.mem[0][1] = 32'h3F800000;
    dut.i_G.mem[0][2] = 32'hBF000000;
    dut.i_G.mem[1][2] = 32'h00000000;
    dut.i_A.mem[0][0] = 32'h3E4CCCCD;

    #1 rstn = 1'b0;
    // A write held during reset must not reach the RAM.
    bus.c_we = 1'b1; bus.c_addr = 4'd5; bus.c_wdata = 32'h11111111;
    #2;
    check_dims("rst", 0, 0, 0);
    check("rst_c", bus.c_rdata, 32'h0);
    check("rst_G", bus.G_rdata, 32'h0);
    check("rst_A", bus.A_rdata, 32'h0);
    check("rst_b", bus.b_rdata, 32'h0);
    tick();
    tick();
    check("rst_c_hold", bus.c_rdata, 32'h0);

    rstn = 1'b1;
    bus.c_we = 1'b0;
    expect_rd(0, 32'hDEADBEEF, "preload_c5");
    expect_rd(1, 32'h3F000000, "preload_G00");
    expect_rd(2, 32'h3E4CCCCD, "preload_A00");
    tick();

    set_dims(2, 3, 1);
    check_dims("dims_231", 2, 3, 1);
    set_dims(11, 3, 1);
    check_dims("dims_n11", 2, 3, 1);
    set_dims(10, 5, 3);
    check_dims("dims_max", 10, 5, 3);
    set_dims(4, 6, 2);
    check_dims("dims_ng6", 10, 5, 3);

    bus.c_we = 1'b1; bus.c_addr = 4'd0; bus.c_wdata = 32'h40A00000;
    tick();
    bus.c_addr = 4'd1; bus.c_wdata = 32'h3F000000;
    tick();
    bus.c_we = 1'b0; bus.c_addr = 4'd0;
    expect_rd(0, 32'h40A00000, "c0");
    tick();
    bus.c_addr = 4'd1;
    expect_rd(0, 32'h3F000000, "c1");
    tick();

    bus.G_raddr = 4'd0; bus.G_caddr = 3'd1;
    expect_rd(1, 32'h3F800000, "G01");
    tick();
    bus.G_raddr = 4'd1; bus.G_caddr = 3'd2;
    expect_rd(1, 32'h00000000, "G12");
    tick();
    bus.G_we = 1'b1; bus.G_raddr = 4'd1; bus.G_caddr = 3'd1; bus.G_wdata = 32'h12345678;
    tick();
    bus.G_we = 1'b0; bus.G_raddr = 4'd0; bus.G_caddr = 3'd1;
    expect_rd(1, 32'h3F800000, "G01_no_alias");
    tick();
    bus.G_raddr = 4'd1;
    expect_rd(1, 32'h12345678, "G11");
    tick();

    bus.A_we = 1'b1; bus.A_raddr = 2'd0; bus.A_caddr = 3'd0; bus.A_wdata = 32'h3F800000;
    expect_rd(2, 32'h3E4CCCCD, "A00_rdw_old");
    tick();
    bus.A_we = 1'b0;
    expect_rd(2, 32'h3F800000, "A00_new");
    tick();

    bus.b_we = 1'b1; bus.b_addr = 2'd0; bus.b_wdata = 32'h3F800000;
    bus.c_addr = 4'd1;
    expect_rd(0, 32'h3F000000, "conc_c1");
    tick();
    bus.b_we = 1'b0;
    expect_rd(3, 32'h3F800000, "conc_b0");
    expect_rd(0, 32'h3F000000, "conc_c1_again");
    tick();

    // Locations past NMAX/NCMAX but inside the power-of-two depth.
    bus.c_we = 1'b1; bus.c_addr = 4'd15; bus.c_wdata = 32'hCAFEF00D;
    bus.A_we = 1'b1; bus.A_raddr = 2'd3; bus.A_caddr = 3'd7; bus.A_wdata = 32'h0BADC0DE;
    tick();
    bus.c_we = 1'b0; bus.A_we = 1'b0;
    expect_rd(0, 32'hCAFEF00D, "c15");
    expect_rd(2, 32'h0BADC0DE, "A37");
    tick();

    bus.c_addr = 4'd0;
    tick();
    check("pre_rst_c0", bus.c_rdata, 32'h40A00000);
    rstn = 1'b0;
    #1;
    check("mid_rst_c", bus.c_rdata, 32'h0);
    check("mid_rst_A", bus.A_rdata, 32'h0);
    check_dims("mid_rst", 0, 0, 0);
    tick();
    rstn = 1'b1;
    expect_rd(0, 32'h40A00000, "post_rst_c0");
    expect_rd(2, 32'h0BADC0DE, "post_rst_A37");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/czonotope_mem.md
CZONOTOPE_MEM -- requirements
Module: czonotope_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width (IEEE-754 single precision; the block stores words and does no arithmetic).
REQ-002 Parameter NMAX, default 10, SHALL set the maximum state dimension (rows of c and G).
REQ-003 Parameter NGMAX, default 5, SHALL set the maximum generator count (columns of G and A).
REQ-004 Parameter NCMAX, default 3, SHALL set the maximum constraint count (rows of A, length of b).
REQ-005 Derived widths SHALL be: AN=$clog2(NMAX), AG=$clog2(NGMAX), AC=$clog2(NCMAX); dimension registers use $clog2(max+1) bits.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, named clk_i and rstn_i.
REQ-007 Ports SHALL be:
- clk_i  in  1  clock.
- rstn_i  in  1  async active-low reset.
- dim_we  in  1  loads n, ng and nc.
- n_wdata, ng_wdata, nc_wdata  in  dim widths  new dimensions.
- n, ng, nc  out  dim widths  current dimensions.
- c_we  in  1; c_addr  in  AN; c_wdata  in  DATA_WIDTH; c_rdata  out  DATA_WIDTH  (center c).
- G_we  in  1; G_raddr  in  AN; G_caddr  in  AG; G_wdata  in  DATA_WIDTH; G_rdata  out  DATA_WIDTH  (generators G).
- A_we  in  1; A_raddr  in  AC; A_caddr  in  AG; A_wdata  in  DATA_WIDTH; A_rdata  out  DATA_WIDTH  (constraints A).
- b_we  in  1; b_addr  in  AC; b_wdata  in  DATA_WIDTH; b_rdata  out  DATA_WIDTH  (constraint vector b).

Function
REQ-008 Each matrix or vector SHALL be an independent single-port RAM of 2^addr-width words per dimension, so all four can be accessed in the same cycle.
REQ-009 Reads SHALL be synchronous: rdata equals mem[addr] sampled at the previous rising clk_i edge (1-cycle latency).
REQ-010 A write SHALL occur at the rising edge where we=1, storing wdata at the addressed location.
REQ-011 Read-during-write to the same address SHALL return the old data; the new data is visible from the next read.
REQ-012 Two-dimensional RAMs SHALL address element [raddr][caddr] (row-major); no aliasing between rows.
REQ-013 While we=0, rdata SHALL follow addr with 1-cycle latency and memory SHALL be unchanged.
REQ-014 dim_we=1 SHALL load n, ng and nc at the clock edge only if n_wdata<=NMAX, ng_wdata<=NGMAX and nc_wdata<=NCMAX; otherwise all three SHALL hold their values.
REQ-015 Addresses at or beyond n/ng/nc but inside the RAM depth SHALL remain readable and writable; dimensions do not gate access.
REQ-016 Addresses beyond the parameter maximum but inside the power-of-two depth SHALL behave as ordinary storage.

Reset
REQ-017 rstn_i=0 SHALL asynchronously clear n, ng, nc and all rdata outputs to 0.
REQ-018 RAM contents SHALL NOT be cleared by reset; writes asserted during reset SHALL be ignored.
REQ-019 Deasserting reset mid-sequence SHALL resume normal 1-cycle reads from the next rising edge.

Structure
REQ-020 Default parameters, derived width functions and a dimension-record typedef (n, ng, nc) SHALL live in a shared package czonotope_pkg.
REQ-021 The 1-D RAM SHALL be sub-module block_ram_1d (params DATA_WIDTH, ADDR_WIDTH; ports clk, we, addr, wdata, rdata), instantiated for c and b.
REQ-022 The 2-D RAM SHALL be sub-module block_ram_2d (params DATA_WIDTH, ROW_ADDR_WIDTH, COL_ADDR_WIDTH; ports clk, we, raddr, caddr, wdata, rdata), instantiated for G and A.
REQ-023 Each RAM SHALL hold its storage in an array named mem, indexed [addr] or [row][col], so benches can preload it hierarchically.
REQ-024 The RAM instances SHALL be named i_c, i_G, i_A and i_b, and the top level SHALL add the reset and output-clearing logic.

Verification
REQ-025 Reset -> n=ng=nc=0 and all rdata=0 immediately; preloaded mem contents are intact after reset.
REQ-026 dim_we with (2,3,1) -> n=2, ng=3, nc=1 next cycle; then (11,3,1) -> values unchanged.
REQ-027 Write c[0]=0x40A00000 and c[1]=0x3F000000, then read addr 0 then 1 -> c_rdata=0x40A00000 then 0x3F000000, each one cycle after its address.
REQ-028 Preload G row 0 = {0x3F000000, 0x3F800000, 0xBF000000}; read [0][1] then [1][2] -> 0x3F800000 then 0x00000000.
REQ-029 Read-during-write A[0][0]: old 0x3E4CCCCD, write 0x3F800000 -> same-cycle read returns 0x3E4CCCCD, next read returns 0x3F800000.
REQ-030 Concurrent write of b[0]=0x3F800000 and read of c[1] in one cycle -> both complete correctly with no cross-talk.
